lru_set_tracker: RTL and testbench
==================================

LRU_SET_TRACKER -- requirements
Module: lru_set_tracker

Interface
REQ-001 The module SHALL have parameter NO_SETS, default 4, meaning the number of independent LRU sets (power of 2, >=2).
REQ-002 The module SHALL have parameter NO_WAYS, default 8, meaning the ways per set (power of 2, >=2).
REQ-003 The module SHALL derive SET_WIDTH=$clog2(NO_SETS) and WAY_WIDTH=$clog2(NO_WAYS), which are not overridable.
REQ-004 The module SHALL have port clk, input, 1, the single clock (all logic on its rising edge).
REQ-005 The module SHALL have port rst_n, input, 1, an asynchronous active-low reset.
REQ-006 The module SHALL have port upd_valid, input, 1, an update request.
REQ-007 The module SHALL have port upd_ready, output, 1, update accepted when high with upd_valid.
REQ-008 The module SHALL have ports upd_set (input, SET_WIDTH) and upd_way (input, WAY_WIDTH), the target set and way.
REQ-009 The module SHALL have port upd_inval, input, 1: 0 = touch (make MRU), 1 = invalidate (make LRU).
REQ-010 The module SHALL have ports qry_valid (input, 1) and qry_set (input, SET_WIDTH), a victim query.
REQ-011 The module SHALL have ports rsp_valid (output, 1) and rsp_way (output, WAY_WIDTH), the query response.
REQ-012 The module SHALL have ports flush_req (input, 1) for a reinitialise-all-sets pulse and flush_busy (output, 1) for flush in progress.

Function
REQ-013 The module SHALL hold per set an ordered list of NO_WAYS way indices, with position 0 = LRU and position NO_WAYS-1 = MRU.
REQ-014 On an accepted touch, the module SHALL move upd_way to position NO_WAYS-1 and shift entries above its old position down one, effective at the same clock edge.
REQ-015 On an accepted invalidate, the module SHALL move upd_way to position 0 and shift entries below its old position up one.
REQ-016 A touch of the current MRU, or an invalidate of the current LRU, SHALL leave the order unchanged.
REQ-017 Only the addressed set SHALL change; at most one update SHALL be applied per cycle.
REQ-018 A query SHALL always be accepted, with rsp_valid high exactly one cycle after qry_valid.
REQ-019 rsp_way SHALL be position 0 of the queried set, read from the state after the edge that registered the query, so it reflects an update accepted in the same cycle as the query.
REQ-020 The FSM SHALL have states IDLE and FLUSH; IDLE goes to FLUSH on flush_req, and FLUSH returns to IDLE after the set counter reaches NO_SETS-1.
REQ-021 In FLUSH, the module SHALL write the identity order (position p = way p) to set counter 0..NO_SETS-1, one set per cycle, taking exactly NO_SETS cycles.
REQ-022 upd_ready SHALL be (state==IDLE) && !flush_req; a flush_req coinciding with upd_valid wins, and the update is not accepted.
REQ-023 flush_busy SHALL be high exactly while state==FLUSH.
REQ-024 flush_req during FLUSH SHALL be ignored.
REQ-025 Any query registered during FLUSH or in its first cycle SHALL respond with rsp_way=0.

Reset
REQ-026 On rst_n low, every set SHALL take the identity order (LRU=0, MRU=NO_WAYS-1), the FSM SHALL go to IDLE with set counter 0, and rsp_valid=0, rsp_way=0, flush_busy=0 and upd_ready=1.
REQ-027 A reset asserted mid-FLUSH SHALL abort the flush, with reset values applying immediately.

Configuration
REQ-028 With macro LRU_SET_TRACKER_INVAL_EN defined, the invalidate operation SHALL behave per REQ-015.
REQ-029 With LRU_SET_TRACKER_INVAL_EN undefined, upd_inval SHALL be ignored and every accepted update SHALL be treated as a touch; the port SHALL remain present.

Verification (NO_SETS=4, NO_WAYS=4)
REQ-030 Release reset, then query set 2 -> rsp_valid next cycle with rsp_way=0, and upd_ready=1.
REQ-031 Touch set1 ways 0,1,2, then query set1 -> 3; query set0 -> 0.
REQ-032 After reset, touch set1 way0 and query set1 in the same cycle -> rsp_way=1; touch set0 way3 (MRU), then query set0 -> 0.
REQ-033 After reset, touch set3 way0, then invalidate set3 way2 and query set3 -> with macro 2; without macro 1.
REQ-034 Touch several sets, then pulse flush_req together with upd_valid -> update not accepted, flush_busy high for 4 cycles, upd_ready low throughout, then queries of all sets -> 0.
REQ-035 Assert rst_n low in the 2nd FLUSH cycle -> flush_busy=0 immediately, all sets return identity order, and upd_ready=1 after release.

Source files
------------

// File: rtl/lru_set_tracker_if.sv
// lru_set_tracker_if: update, query and flush signals of the LRU set tracker.
interface lru_set_tracker_if #(
   parameter int NO_SETS = 4,
   parameter int NO_WAYS = 8
);
   localparam int SET_WIDTH = $clog2(NO_SETS);
   localparam int WAY_WIDTH = $clog2(NO_WAYS);
   logic upd_valid, upd_ready, upd_inval, qry_valid, rsp_valid, flush_req, flush_busy;
   logic [SET_WIDTH-1:0] upd_set, qry_set;
   logic [WAY_WIDTH-1:0] upd_way, rsp_way;
   modport master (
      output upd_valid, upd_set, upd_way, upd_inval, qry_valid, qry_set, flush_req,
      input  upd_ready, rsp_valid, rsp_way, flush_busy
   );
   modport slave (
      input  upd_valid, upd_set, upd_way, upd_inval, qry_valid, qry_set, flush_req,
      output upd_ready, rsp_valid, rsp_way, flush_busy
   );
endinterface

// File: rtl/lru_set_tracker.sv
// lru_set_tracker: per-set true-LRU way order with victim query and flush.
// Invalidate (make-LRU) is enabled by LRU_SET_TRACKER_INVAL_EN; otherwise updates are touches.
module lru_set_tracker #(
   parameter int NO_SETS = 4,
   parameter int NO_WAYS = 8
) (
   input logic clk,
   input logic rst_n,
   lru_set_tracker_if.slave bus
);
   localparam int SET_WIDTH = $clog2(NO_SETS);
   localparam int WAY_WIDTH = $clog2(NO_WAYS);
   typedef enum logic {IDLE, FLUSH} state_t;
   state_t state, state_nxt;
   logic [SET_WIDTH-1:0] cnt, qset;
   logic rsp_zero, inval;
   logic [WAY_WIDTH-1:0] order [NO_SETS][NO_WAYS];
   logic [WAY_WIDTH-1:0] cur [NO_WAYS];
   logic [WAY_WIDTH-1:0] row [NO_WAYS];
   int pos;
`ifdef LRU_SET_TRACKER_INVAL_EN
   assign inval = bus.upd_inval;
`else
   logic unused_inval;
   assign unused_inval = bus.upd_inval;
   assign inval = 1'b0;
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      if (state == IDLE && bus.flush_req) state_nxt = FLUSH;
      else if (state == FLUSH && cnt == SET_WIDTH'(NO_SETS - 1)) state_nxt = IDLE;
      bus.upd_ready = state == IDLE && !bus.flush_req;
      bus.flush_busy = state == FLUSH;
      bus.rsp_way = (bus.rsp_valid && !rsp_zero) ? order[qset][0] : '0;
   end
   // New order of the addressed set: the target way slides to MRU (touch) or LRU (invalidate).
   always_comb begin
      cur = order[bus.upd_set];
      pos = 0;
      for (int p = 0; p < NO_WAYS; p++)
         if (cur[p] == bus.upd_way) pos = p;
      for (int p = 0; p < NO_WAYS; p++)
         row[p] = inval ? (p == 0 ? bus.upd_way : p <= pos ? cur[p == 0 ? 0 : p - 1] : cur[p])
                        : (p == NO_WAYS - 1 ? bus.upd_way : p >= pos ? cur[p == NO_WAYS - 1 ? p : p + 1] : cur[p]);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int s = 0; s < NO_SETS; s++)
            for (int p = 0; p < NO_WAYS; p++)
               order[s][p] <= WAY_WIDTH'(p);
         cnt <= '0;
         qset <= '0;
         rsp_zero <= 1'b0;
         bus.rsp_valid <= 1'b0;
      end else begin
         if (state == FLUSH) begin
            for (int p = 0; p < NO_WAYS; p++)
               order[cnt][p] <= WAY_WIDTH'(p);
            cnt <= cnt == SET_WIDTH'(NO_SETS - 1) ? '0 : cnt + 1'b1;
         end else if (bus.upd_valid && bus.upd_ready) begin
            order[bus.upd_set] <= row;
         end
         bus.rsp_valid <= bus.qry_valid;
         qset <= bus.qry_set;
         // Queries taken while a flush starts or runs see a half-initialised table; answer way 0.
         rsp_zero <= state == FLUSH || bus.flush_req;
      end
endmodule

// File: tb/tb_lru_set_tracker.sv
// tb_lru_set_tracker: directed checks of touch/invalidate ordering, queries, flush and reset.
module tb_lru_set_tracker;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   lru_set_tracker_if #(.NO_SETS(4), .NO_WAYS(4)) bus ();
   lru_set_tracker #(.NO_SETS(4), .NO_WAYS(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`ifdef LRU_SET_TRACKER_INVAL_EN
   localparam logic [31:0] EXP_INV = 2;
`else
   localparam logic [31:0] EXP_INV = 1;
`endif
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      bus.upd_valid = 1'b0;
      bus.qry_valid = 1'b0;
      bus.flush_req = 1'b0;
      bus.upd_inval = 1'b0;
   endtask
   task automatic upd(input logic [1:0] s, input logic [1:0] w, input logic inv);
      bus.upd_valid = 1'b1;
      bus.upd_set = s;
      bus.upd_way = w;
      bus.upd_inval = inv;
   endtask
   task automatic qry(input logic [1:0] s);
      bus.qry_valid = 1'b1;
      bus.qry_set = s;
   endtask
   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask
   task automatic query_expect(input string tag, input logic [1:0] s, input logic [31:0] exp);
      idle();
      qry(s);
      step();
      bus.qry_valid = 1'b0;
      check({tag, "_valid"}, 32'(bus.rsp_valid), 1);
      check(tag, 32'(bus.rsp_way), exp);
   endtask
   initial begin
      idle();
      bus.upd_set = '0;
      bus.upd_way = '0;
      bus.qry_set = '0;
      step();
      check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      check("rst_rsp_way", 32'(bus.rsp_way), 0);
      check("rst_flush_busy", 32'(bus.flush_busy), 0);
      check("rst_upd_ready", 32'(bus.upd_ready), 1);
      rst_n = 1'b1;
      step();
      query_expect("q_set2_after_reset", 2'd2, 0);
      check("ready_after_reset", 32'(bus.upd_ready), 1);
      step();
      check("rsp_valid_drops", 32'(bus.rsp_valid), 0);
      // set1: 0123 -> 1230 -> 2301 -> 3012
      upd(2'd1, 2'd0, 1'b0); step();
      upd(2'd1, 2'd1, 1'b0); step();
      upd(2'd1, 2'd2, 1'b0); step();
      query_expect("q_set1_after_touches", 2'd1, 3);
      query_expect("q_set0_untouched", 2'd0, 0);
      upd(2'd1, 2'd3, 1'b0); step();
      query_expect("q_set1_touch_lru", 2'd1, 0);
      do_reset();
      upd(2'd1, 2'd0, 1'b0);
      qry(2'd1);
      step();
      idle();
      check("q_same_cycle_update", 32'(bus.rsp_way), 1);
      upd(2'd0, 2'd3, 1'b0); step();
      query_expect("q_touch_mru_noop", 2'd0, 0);
      do_reset();
      upd(2'd3, 2'd0, 1'b0); step();
      upd(2'd3, 2'd2, 1'b1);
      qry(2'd3);
      step();
      idle();
      check("q_after_inval", 32'(bus.rsp_way), EXP_INV);
      upd(2'd3, 2'd2, 1'b1); step();
      query_expect("q_inval_lru_noop", 2'd3, EXP_INV);
      do_reset();
      upd(2'd0, 2'd0, 1'b0); step();
      upd(2'd1, 2'd0, 1'b0); step();
      upd(2'd2, 2'd0, 1'b0); step();
      upd(2'd3, 2'd1, 1'b0); step();
      upd(2'd0, 2'd1, 1'b0);
      bus.flush_req = 1'b1;
      qry(2'd1);
      #1;
      check("flush_blocks_ready", 32'(bus.upd_ready), 0);
      step();
      idle();
      check("q_in_flush_start", 32'(bus.rsp_way), 0);
      qry(2'd2);
      for (int i = 0; i < 4; i++) begin
         check("flush_busy_high", 32'(bus.flush_busy), 1);
         check("flush_ready_low", 32'(bus.upd_ready), 0);
         step();
         idle();
         if (i == 0) begin
            check("q_during_flush", 32'(bus.rsp_way), 0);
            bus.flush_req = 1'b1;
         end
      end
      check("flush_busy_done", 32'(bus.flush_busy), 0);
      check("flush_ready_back", 32'(bus.upd_ready), 1);
      query_expect("q_flush_set0", 2'd0, 0);
      query_expect("q_flush_set1", 2'd1, 0);
      query_expect("q_flush_set2", 2'd2, 0);
      query_expect("q_flush_set3", 2'd3, 0);
      upd(2'd2, 2'd0, 1'b0); step();
      upd(2'd3, 2'd0, 1'b0); step();
      idle();
      bus.flush_req = 1'b1;
      step();
      idle();
      step();
      check("flush_busy_2nd_cycle", 32'(bus.flush_busy), 1);
      rst_n = 1'b0;
      #1;
      check("abort_flush_busy", 32'(bus.flush_busy), 0);
      check("abort_upd_ready", 32'(bus.upd_ready), 1);
      step();
      rst_n = 1'b1;
      step();
      check("abort_ready_after", 32'(bus.upd_ready), 1);
      check("abort_busy_after", 32'(bus.flush_busy), 0);
      query_expect("q_abort_set2", 2'd2, 0);
      query_expect("q_abort_set3", 2'd3, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
